mc_main_fsm: RTL and testbench

//  Moore main-control state machine for the multicycle MIPS core: sequences each instruction

---
 rtl/mc_main_fsm.sv | 294 +++++++++++++++++++++++++++++
 tb/tb_mc_main_fsm.sv | 210 +++++++++++++++++++++
 2 files changed

// File: rtl/mc_main_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : mc_main_fsm
//  Purpose  : Moore main-control state machine for the multicycle MIPS core.
//             Walks each instruction through fetch / decode / execute /
//             memory / writeback and drives the per-cycle datapath strobes.
//             Also flags unsupported opcodes and counts retired instructions.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk         in   1      rising-edge clock
//    reset       in   1      asynchronous, active-low reset
//    op          in   6      opcode field instr[31:26] (held stable by the IR)
//    IorD        out  1      memory address select: 0=PC, 1=ALUOut
//    IRwrite     out  1      load instruction register
//    memwrite    out  1      memory write strobe
//    memtoreg    out  1      regfile write data: 0=ALUOut, 1=Data reg
//    regwrite    out  1      regfile write enable
//    regdst      out  1      destination register: 0=rt, 1=rd
//    alusrcA     out  1      ALU A: 0=PC, 1=A reg
//    alusrcB     out  2      ALU B: 00=B, 01=4, 10=SignImm, 11=SignImm<<2
//    aluop       out  2      00=add, 01=sub, 10=funct decode
//    pcsrc       out  2      00=ALUResult, 01=ALUOut, 10=jump target
//    pcwrite     out  1      unconditional PC write
//    branch      out  1      conditional PC write (qualified by zero outside)
//    state       out  4      current state encoding
//    instr_done  out  1      high in the terminal state of a legal instruction
//    illegal     out  1      one-cycle pulse after DECODE saw a bad opcode
//    retired     out  CNT_W  completed legal instruction count (wrapping)
// ============================================================================
module mc_main_fsm #(
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [5:0]       op,
    output logic             IorD,
    output logic             IRwrite,
    output logic             memwrite,
    output logic             memtoreg,
    output logic             regwrite,
    output logic             regdst,
    output logic             alusrcA,
    output logic [1:0]       alusrcB,
    output logic [1:0]       aluop,
    output logic [1:0]       pcsrc,
    output logic             pcwrite,
    output logic             branch,
    output logic [3:0]       state,
    output logic             instr_done,
    output logic             illegal,
    output logic [CNT_W-1:0] retired
);

    // ------------------------------------------------------------------------
    // State encoding (fixed values, visible on the state port)
    // ------------------------------------------------------------------------
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEMADR  = 4'd2,
        S_MEMRD   = 4'd3,
        S_MEMWB   = 4'd4,
        S_MEMWR   = 4'd5,
        S_RTYPEEX = 4'd6,
        S_RTYPEWB = 4'd7,
        S_BEQEX   = 4'd8,
        S_ADDIEX  = 4'd9,
        S_ADDIWB  = 4'd10,
        S_JEX     = 4'd11
    } state_e;

    localparam logic [5:0] c_op_lw    = 6'b100011;
    localparam logic [5:0] c_op_sw    = 6'b101011;
    localparam logic [5:0] c_op_rtype = 6'b000000;
    localparam logic [5:0] c_op_beq   = 6'b000100;
    localparam logic [5:0] c_op_addi  = 6'b001000;
    localparam logic [5:0] c_op_j     = 6'b000010;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    logic [3:0]       r_state;
    logic             r_iord;
    logic             r_irwrite;
    logic             r_memwrite;
    logic             r_memtoreg;
    logic             r_regwrite;
    logic             r_regdst;
    logic             r_alusrca;
    logic [1:0]       r_alusrcb;
    logic [1:0]       r_aluop;
    logic [1:0]       r_pcsrc;
    logic             r_pcwrite;
    logic             r_branch;
    logic             r_done;
    logic             r_illegal;
    logic [CNT_W-1:0] r_retired;

    // ------------------------------------------------------------------------
    // Next-state logic
    // ------------------------------------------------------------------------
    logic [3:0] w_next;
    logic       w_bad_op;

    always_comb begin
        w_next   = S_FETCH;
        w_bad_op = 1'b0;
        case (r_state)
            S_FETCH:   w_next = S_DECODE;
            S_DECODE: begin
                case (op)
                    c_op_lw,
                    c_op_sw:    w_next = S_MEMADR;
                    c_op_rtype: w_next = S_RTYPEEX;
                    c_op_beq:   w_next = S_BEQEX;
                    c_op_addi:  w_next = S_ADDIEX;
                    c_op_j:     w_next = S_JEX;
                    default: begin
                        w_next   = S_FETCH;
                        w_bad_op = 1'b1;
                    end
                endcase
            end
            // Only lw/sw reach MEMADR and the IR holds op, so sw is the
            // only case that needs distinguishing here.
            S_MEMADR:  w_next = (op == c_op_sw) ? S_MEMWR : S_MEMRD;
            S_MEMRD:   w_next = S_MEMWB;
            S_RTYPEEX: w_next = S_RTYPEWB;
            S_ADDIEX:  w_next = S_ADDIWB;
            // Terminal states and the unused codes 12-15 all return to FETCH.
            default:   w_next = S_FETCH;
        endcase
    end

    // ------------------------------------------------------------------------
    // Output decode of the *next* state. Registering this alongside the state
    // keeps every output a pure function of the current state while giving
    // glitch-free flop outputs to the downstream controller.
    // ------------------------------------------------------------------------
    logic       w_iord;
    logic       w_irwrite;
    logic       w_memwrite;
    logic       w_memtoreg;
    logic       w_regwrite;
    logic       w_regdst;
    logic       w_alusrca;
    logic [1:0] w_alusrcb;
    logic [1:0] w_aluop;
    logic [1:0] w_pcsrc;
    logic       w_pcwrite;
    logic       w_branch;
    logic       w_done;

    always_comb begin
        w_iord     = 1'b0;
        w_irwrite  = 1'b0;
        w_memwrite = 1'b0;
        w_memtoreg = 1'b0;
        w_regwrite = 1'b0;
        w_regdst   = 1'b0;
        w_alusrca  = 1'b0;
        w_alusrcb  = 2'b00;
        w_aluop    = 2'b00;
        w_pcsrc    = 2'b00;
        w_pcwrite  = 1'b0;
        w_branch   = 1'b0;
        w_done     = 1'b0;
        case (w_next)
            S_FETCH: begin
                w_irwrite = 1'b1;
                w_pcwrite = 1'b1;
                w_alusrcb = 2'b01;
            end
            S_DECODE: begin
                w_alusrcb = 2'b11;
            end
            S_MEMADR: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            S_MEMRD: begin
                w_iord = 1'b1;
            end
            S_MEMWB: begin
                w_regwrite = 1'b1;
                w_memtoreg = 1'b1;
                w_done     = 1'b1;
            end
            S_MEMWR: begin
                w_iord     = 1'b1;
                w_memwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_RTYPEEX: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b10;
            end
            S_RTYPEWB: begin
                w_regwrite = 1'b1;
                w_regdst   = 1'b1;
                w_done     = 1'b1;
            end
            S_BEQEX: begin
                w_alusrca = 1'b1;
                w_aluop   = 2'b01;
                w_pcsrc   = 2'b01;
                w_branch  = 1'b1;
                w_done    = 1'b1;
            end
            S_ADDIEX: begin
                w_alusrca = 1'b1;
                w_alusrcb = 2'b10;
            end
            S_ADDIWB: begin
                w_regwrite = 1'b1;
                w_done     = 1'b1;
            end
            S_JEX: begin
                w_pcwrite = 1'b1;
                w_pcsrc   = 2'b10;
                w_done    = 1'b1;
            end
            default: begin
            end
        endcase
    end

    // ------------------------------------------------------------------------
    // State, registered outputs, illegal pulse and retire counter
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state    <= S_FETCH;
            // FETCH decode is visible while reset is held.
            r_iord     <= 1'b0;
            r_irwrite  <= 1'b1;
            r_memwrite <= 1'b0;
            r_memtoreg <= 1'b0;
            r_regwrite <= 1'b0;
            r_regdst   <= 1'b0;
            r_alusrca  <= 1'b0;
            r_alusrcb  <= 2'b01;
            r_aluop    <= 2'b00;
            r_pcsrc    <= 2'b00;
            r_pcwrite  <= 1'b1;
            r_branch   <= 1'b0;
            r_done     <= 1'b0;
            r_illegal  <= 1'b0;
            r_retired  <= '0;
        end else begin
            r_state    <= w_next;
            r_iord     <= w_iord;
            r_irwrite  <= w_irwrite;
            r_memwrite <= w_memwrite;
            r_memtoreg <= w_memtoreg;
            r_regwrite <= w_regwrite;
            r_regdst   <= w_regdst;
            r_alusrca  <= w_alusrca;
            r_alusrcb  <= w_alusrcb;
            r_aluop    <= w_aluop;
            r_pcsrc    <= w_pcsrc;
            r_pcwrite  <= w_pcwrite;
            r_branch   <= w_branch;
            r_done     <= w_done;
            // The bad-op condition only exists in DECODE, whose successor is
            // FETCH, so this naturally self-clears one cycle later.
            r_illegal  <= w_bad_op;
            // Count on the edge leaving a terminal state; wraps naturally.
            if (r_done) begin
                r_retired <= r_retired + CNT_W'(1);
            end
        end
    end

    assign IorD       = r_iord;
    assign IRwrite    = r_irwrite;
    assign memwrite   = r_memwrite;
    assign memtoreg   = r_memtoreg;
    assign regwrite   = r_regwrite;
    assign regdst     = r_regdst;
    assign alusrcA    = r_alusrca;
    assign alusrcB    = r_alusrcb;
    assign aluop      = r_aluop;
    assign pcsrc      = r_pcsrc;
    assign pcwrite    = r_pcwrite;
    assign branch     = r_branch;
    assign state      = r_state;
    assign instr_done = r_done;
    assign illegal    = r_illegal;
    assign retired    = r_retired;

endmodule
`default_nettype wire

// File: tb/tb_mc_main_fsm.sv
`default_nettype none
// ============================================================================
//  Module   : tb_mc_main_fsm
//  Purpose  : Self-checking bench for mc_main_fsm. Two instances (CNT_W=32 and
//             CNT_W=4) share clock, reset and opcode. Each instruction's state
//             path and per-state strobes come from a table-level model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_mc_main_fsm;

    logic       clk;
    logic       reset;
    logic [5:0] op;

    logic       a_iord, a_irw, a_mw, a_m2r, a_rw, a_rd, a_asa, a_pw, a_br;
    logic [1:0] a_asb, a_aop, a_pcs;
    logic [3:0] a_state;
    logic       a_done, a_ill;
    logic [31:0] a_ret;

    logic       b_iord, b_irw, b_mw, b_m2r, b_rw, b_rd, b_asa, b_pw, b_br;
    logic [1:0] b_asb, b_aop, b_pcs;
    logic [3:0] b_state;
    logic       b_done, b_ill;
    logic [3:0] b_ret;

    mc_main_fsm #(.CNT_W(32)) dut_a (
        .clk(clk), .reset(reset), .op(op),
        .IorD(a_iord), .IRwrite(a_irw), .memwrite(a_mw), .memtoreg(a_m2r),
        .regwrite(a_rw), .regdst(a_rd), .alusrcA(a_asa), .alusrcB(a_asb),
        .aluop(a_aop), .pcsrc(a_pcs), .pcwrite(a_pw), .branch(a_br),
        .state(a_state), .instr_done(a_done), .illegal(a_ill), .retired(a_ret)
    );

    mc_main_fsm #(.CNT_W(4)) dut_b (
        .clk(clk), .reset(reset), .op(op),
        .IorD(b_iord), .IRwrite(b_irw), .memwrite(b_mw), .memtoreg(b_m2r),
        .regwrite(b_rw), .regdst(b_rd), .alusrcA(b_asa), .alusrcB(b_asb),
        .aluop(b_aop), .pcsrc(b_pcs), .pcwrite(b_pw), .branch(b_br),
        .state(b_state), .instr_done(b_done), .illegal(b_ill), .retired(b_ret)
    );

    // Strobe bundle: IorD IRwrite memwrite memtoreg regwrite regdst alusrcA
    //                alusrcB aluop pcsrc pcwrite branch
    wire [14:0] a_str = {a_iord, a_irw, a_mw, a_m2r, a_rw, a_rd, a_asa,
                         a_asb, a_aop, a_pcs, a_pw, a_br};
    wire [14:0] b_str = {b_iord, b_irw, b_mw, b_m2r, b_rw, b_rd, b_asa,
                         b_asb, b_aop, b_pcs, b_pw, b_br};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;
    int cnt   = 0;       // model of retired instructions (unbounded)
    bit prev_ill = 1'b0; // model: previous instruction was illegal

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        ntot++;
        assert (obs === exp) npass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    // Expected strobes for a named state, straight from the control table.
    function automatic logic [14:0] exp_str(input int s);
        logic iord, irw, mw, m2r, rw, rd, asa, pw, br;
        logic [1:0] asb, aop, pcs;
        {iord, irw, mw, m2r, rw, rd, asa, pw, br} = '0;
        asb = 2'b00; aop = 2'b00; pcs = 2'b00;
        case (s)
            0:  begin irw = 1; pw = 1; asb = 2'b01; end           // FETCH
            1:  asb = 2'b11;                                      // DECODE
            2:  begin asa = 1; asb = 2'b10; end                   // MEMADR
            3:  iord = 1;                                         // MEMRD
            4:  begin rw = 1; m2r = 1; end                        // MEMWB
            5:  begin iord = 1; mw = 1; end                       // MEMWR
            6:  begin asa = 1; aop = 2'b10; end                   // RTYPEEX
            7:  begin rw = 1; rd = 1; end                         // RTYPEWB
            8:  begin asa = 1; aop = 2'b01; pcs = 2'b01; br = 1; end // BEQEX
            9:  begin asa = 1; asb = 2'b10; end                   // ADDIEX
            10: rw = 1;                                           // ADDIWB
            11: begin pw = 1; pcs = 2'b10; end                    // JEX
            default: ;
        endcase
        return {iord, irw, mw, m2r, rw, rd, asa, asb, aop, pcs, pw, br};
    endfunction

    function automatic bit is_terminal(input int s);
        return (s == 4) || (s == 5) || (s == 7) || (s == 8) || (s == 10) || (s == 11);
    endfunction

    // Drive one instruction from its FETCH cycle (called at a negedge with
    // the DUT in FETCH) and check every cycle of its path.
    task automatic run_instr(input logic [5:0] o);
        int  seq[$];
        bit  legal;
        op = o;
        legal = 1'b1;
        seq.push_back(0);
        seq.push_back(1);
        case (o)
            6'b100011: begin seq.push_back(2); seq.push_back(3); seq.push_back(4); end
            6'b101011: begin seq.push_back(2); seq.push_back(5); end
            6'b000000: begin seq.push_back(6); seq.push_back(7); end
            6'b000100: seq.push_back(8);
            6'b001000: begin seq.push_back(9); seq.push_back(10); end
            6'b000010: seq.push_back(11);
            default:   legal = 1'b0;
        endcase
        foreach (seq[i]) begin
            chk($sformatf("state[op=%b,c%0d]", o, i), {28'd0, a_state}, seq[i]);
            chk($sformatf("strobes[op=%b,s%0d]", o, seq[i]), {17'd0, a_str}, {17'd0, exp_str(seq[i])});
            chk($sformatf("illegal[op=%b,c%0d]", o, i), {31'd0, a_ill}, {31'd0, (i == 0) && prev_ill});
            chk($sformatf("done[op=%b,s%0d]", o, seq[i]), {31'd0, a_done}, {31'd0, is_terminal(seq[i])});
            chk($sformatf("retired32[op=%b]", o), a_ret, cnt);
            chk($sformatf("b_state[op=%b,c%0d]", o, i), {28'd0, b_state}, seq[i]);
            chk($sformatf("retired4[op=%b]", o), {28'd0, b_ret}, cnt % 16);
            @(negedge clk);
        end
        if (legal) cnt++;
        prev_ill = !legal;
    endtask

    logic [5:0] legal_ops [6];

    initial begin
        legal_ops[0] = 6'b100011; legal_ops[1] = 6'b101011;
        legal_ops[2] = 6'b000000; legal_ops[3] = 6'b000100;
        legal_ops[4] = 6'b001000; legal_ops[5] = 6'b000010;

        // Reset held: FETCH decode, counters cleared.
        reset = 1'b0;
        op    = 6'b100011;
        @(negedge clk);
        @(negedge clk);
        chk("rst_state", {28'd0, a_state}, 32'd0);
        chk("rst_strobes", {17'd0, a_str}, {17'd0, exp_str(0)});
        chk("rst_illegal", {31'd0, a_ill}, 32'd0);
        chk("rst_retired", a_ret, 32'd0);
        reset = 1'b1;

        // Directed sequences.
        run_instr(6'b100011);   // lw
        run_instr(6'b101011);   // sw
        run_instr(6'b000100);   // beq
        run_instr(6'b000010);   // j
        run_instr(6'b111111);   // illegal
        run_instr(6'b000000);   // R-type right after illegal
        chk("retired_after_directed", a_ret, 32'd5);

        // Randomized mix of legal and arbitrary opcodes.
        for (int n = 0; n < 60; n++) begin
            if ($urandom_range(0, 9) < 7)
                run_instr(legal_ops[$urandom_range(0, 5)]);
            else
                run_instr(6'($urandom));
        end
        run_instr(6'b001000);

        // Asynchronous reset in the middle of lw (in MEMRD).
        op = 6'b100011;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("pre_reset_memrd", {28'd0, a_state}, 32'd3);
        chk("pre_reset_retired_nonzero", {31'd0, a_ret != 32'd0}, 32'd1);
        #2 reset = 1'b0;
        #1;
        chk("async_rst_state", {28'd0, a_state}, 32'd0);
        chk("async_rst_retired", a_ret, 32'd0);
        chk("async_rst_retired4", {28'd0, b_ret}, 32'd0);
        chk("async_rst_strobes", {17'd0, a_str}, {17'd0, exp_str(0)});
        @(negedge clk);
        reset    = 1'b1;
        cnt      = 0;
        prev_ill = 1'b0;
        run_instr(6'b000000);

        // Unreachable code 13 returns to FETCH. Forced while in JEX, whose
        // successor is FETCH regardless of how the release resolves.
        op = 6'b000010;
        @(negedge clk);
        @(negedge clk);
        force dut_a.r_state = 4'd13;
        #1;
        chk("forced_state13", {28'd0, a_state}, 32'd13);
        release dut_a.r_state;
        @(negedge clk);
        chk("state13_next", {28'd0, a_state}, 32'd0);
        cnt++;
        chk("retired_after_forced_j", a_ret, cnt);

        // 16 addi from a clean count: 4-bit counter wraps 15 -> 0.
        #2 reset = 1'b0;
        @(negedge clk);
        reset    = 1'b1;
        cnt      = 0;
        prev_ill = 1'b0;
        for (int n = 0; n < 15; n++) run_instr(6'b001000);
        chk("retired4_at_15", {28'd0, b_ret}, 32'd15);
        run_instr(6'b001000);
        chk("retired4_wrapped", {28'd0, b_ret}, 32'd0);
        chk("retired32_16", a_ret, 32'd16);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
`default_nettype wire
